// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: FIR sample stream and FFT engine signals around fft_frame_ctrl.
// The slave modport is the controller; the master modport is its environment.
// drop_cnt exists only when FFT_CTRL_DROP_CNT_EN is defined.
interface fft_frame_ctrl_if #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned ADDR_W   = 4
);
    logic                fir_valid;
    logic [SAMPLE_W-1:0] fir_d;
    logic                eng_ready;
    logic                eng_start;
    logic                eng_bank;
    logic [ADDR_W-1:0]   eng_rd_addr;
    logic [SAMPLE_W-1:0] eng_rd_data;
    logic                eng_done;
    logic [6:0]          frame_cnt;
    logic                all_done;
    logic                overflow;
`ifdef FFT_CTRL_DROP_CNT_EN
    logic [7:0]          drop_cnt;

    modport slave (
        input  fir_valid, fir_d, eng_ready, eng_rd_addr, eng_done,
        output eng_start, eng_bank, eng_rd_data, frame_cnt, all_done, overflow, drop_cnt
    );

    modport master (
        output fir_valid, fir_d, eng_ready, eng_rd_addr, eng_done,
        input  eng_start, eng_bank, eng_rd_data, frame_cnt, all_done, overflow, drop_cnt
    );
`else
    modport slave (
        input  fir_valid, fir_d, eng_ready, eng_rd_addr, eng_done,
        output eng_start, eng_bank, eng_rd_data, frame_cnt, all_done, overflow
    );

    modport master (
        output fir_valid, fir_d, eng_ready, eng_rd_addr, eng_done,
        input  eng_start, eng_bank, eng_rd_data, frame_cnt, all_done, overflow
    );
`endif
endinterface

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: collects FIR samples into two ping-pong banks, launches the
// 16-point FFT engine on each full bank in fill order, serves engine reads and
// counts completed frames. Optional macro FFT_CTRL_DROP_CNT_EN adds a
// saturating 8-bit count of dropped samples (drop_cnt).
module fft_frame_ctrl #(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned NUM_FRAMES = 64
) (
    input  logic           clk,
    input  logic           rst,
    fft_frame_ctrl_if.slave bus
);
    localparam int unsigned ADDR_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned CNT_W  = 7;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  LAST_FRAME = CNT_W'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_BUSY
    } bank_state_t;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t                  state;
    state_t                  state_next;
    bank_state_t [1:0]       bank_state;
    bank_state_t [1:0]       bank_state_next;
    logic [SAMPLE_W-1:0]     mem [2][FRAME_LEN];

    logic                    wr_bank;
    logic [ADDR_W-1:0]       wr_addr;
    // Next bank to hand to the engine; follows fill order because banks fill alternately.
    logic                    launch_bank;

    logic                    launch_c;
    logic                    release_c;
    logic                    accept_c;
    logic                    drop_c;
    bank_state_t             wr_target_c;

    // Launch sequencer: next state plus launch/release strobes.
    always_comb begin
        state_next = state;
        launch_c   = 1'b0;
        release_c  = 1'b0;
        case (state)
            IDLE: begin
                if ((bank_state[launch_bank] == BANK_FULL) && bus.eng_ready) begin
                    launch_c   = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.eng_done) begin
                    release_c  = 1'b1;
                    state_next = (bus.frame_cnt == LAST_FRAME) ? FINISH : IDLE;
                end
            end
            FINISH: begin
                state_next = FINISH;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sample acceptance; a bank released this cycle already counts as empty.
    always_comb begin
        wr_target_c = bank_state[wr_bank];
        if (release_c && (bus.eng_bank == wr_bank)) begin
            wr_target_c = BANK_EMPTY;
        end
        accept_c = 1'b0;
        drop_c   = 1'b0;
        if (bus.fir_valid && !bus.all_done) begin
            if ((wr_target_c == BANK_EMPTY) || (wr_target_c == BANK_FILLING)) begin
                accept_c = 1'b1;
            end else begin
                drop_c = 1'b1;
            end
        end
    end

    // Per-bank lifecycle; launch and release never hit the bank being written.
    always_comb begin
        bank_state_next = bank_state;
        if (release_c) begin
            bank_state_next[bus.eng_bank] = BANK_EMPTY;
        end
        if (launch_c) begin
            bank_state_next[launch_bank] = BANK_BUSY;
        end
        if (accept_c) begin
            bank_state_next[wr_bank] = (wr_addr == LAST_ADDR) ? BANK_FULL : BANK_FILLING;
        end
    end

    // Control state, fill pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            bank_state[0]   <= BANK_EMPTY;
            bank_state[1]   <= BANK_EMPTY;
            wr_bank         <= 1'b0;
            wr_addr         <= '0;
            launch_bank     <= 1'b0;
            bus.eng_start   <= 1'b0;
            bus.eng_bank    <= 1'b0;
            bus.eng_rd_data <= '0;
            bus.frame_cnt   <= '0;
            bus.all_done    <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            state         <= state_next;
            bank_state    <= bank_state_next;
            bus.eng_start <= launch_c;
            if (launch_c) begin
                bus.eng_bank <= launch_bank;
                launch_bank  <= ~launch_bank;
            end
            if (release_c) begin
                bus.frame_cnt <= bus.frame_cnt + CNT_W'(1);
            end
            if (state == FINISH) begin
                bus.all_done <= 1'b1;
            end
            if (drop_c) begin
                bus.overflow <= 1'b1;
            end
            if (accept_c) begin
                wr_addr <= wr_addr + ADDR_W'(1);
                if (wr_addr == LAST_ADDR) begin
                    wr_addr <= '0;
                    wr_bank <= ~wr_bank;
                end
            end
            bus.eng_rd_data <= mem[bus.eng_bank][bus.eng_rd_addr];
        end
    end

    // Sample storage; contents are not cleared by reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (rst && accept_c) begin
            mem[wr_bank][wr_addr] <= bus.fir_d;
        end
    end

`ifdef FFT_CTRL_DROP_CNT_EN
    // Saturating count of dropped samples.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.drop_cnt <= '0;
        end else if (drop_c && (bus.drop_cnt != 8'hFF)) begin
            bus.drop_cnt <= bus.drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed and randomized checks of fft_frame_ctrl against a
// frame-level reference model (held-frame count, launch queue, sample store).
module tb_fft_frame_ctrl;
    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned FRAME_LEN  = 16;
    localparam int unsigned NUM_FRAMES = 4;
    localparam int unsigned ADDR_W     = 4;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    fft_frame_ctrl_if #(.SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W)) bus ();

    fft_frame_ctrl #(
        .SAMPLE_W  (SAMPLE_W),
        .FRAME_LEN (FRAME_LEN),
        .NUM_FRAMES(NUM_FRAMES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_mem   [2][16];
    bit          m_known [2][16];
    int          m_occ;          // frames held: full-awaiting-launch plus in engine
    int          m_fill_bank;
    int          m_fill_cnt;
    int          m_frames;
    int          m_drops;
    int          m_launch_q[$];  // full banks in fill order
    int          m_eng_bank;
    bit          m_inflight;
    bit          m_start_prev;
    bit          m_finished;
    bit          m_all_done;
    bit          m_overflow;
    bit          exp_start;
    logic [15:0] exp_rd;
    bit          exp_rd_known;

    // Engine emulation
    bit auto_eng;
    int eng_timer;
    int eng_lat_min;
    int eng_lat_max;

    task automatic model_reset();
        m_occ = 0; m_fill_bank = 0; m_fill_cnt = 0; m_frames = 0; m_drops = 0;
        m_launch_q.delete();
        m_eng_bank = 0; m_inflight = 0; m_start_prev = 0;
        m_finished = 0; m_all_done = 0; m_overflow = 0;
        exp_start = 0; exp_rd = 16'h0; exp_rd_known = 1;
        eng_timer = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then sample.
    task automatic step(input bit v, input logic [15:0] d, input bit rdy,
                        input bit dn_manual, input logic [3:0] addr);
        bit dn;
        bit launch;
        bit rel;
        bit fin_prev;
        dn = dn_manual | (auto_eng && m_inflight && (eng_timer == 1));
        bus.fir_valid   = v;
        bus.fir_d       = d;
        bus.eng_ready   = rdy;
        bus.eng_done    = dn;
        bus.eng_rd_addr = addr;
        if (!rst) begin
            model_reset();
        end else begin
            exp_rd       = m_mem[m_eng_bank][addr];
            exp_rd_known = m_known[m_eng_bank][addr];
            fin_prev     = m_finished;
            launch = !m_inflight && !m_finished && (m_launch_q.size() > 0) && rdy;
            rel    = dn && m_inflight && !m_start_prev;
            if (rel) begin
                m_occ--;
                m_inflight = 0;
                m_frames++;
                if (m_frames == NUM_FRAMES) m_finished = 1;
            end
            if (v && !m_all_done) begin
                if (m_occ < 2) begin
                    m_mem[m_fill_bank][m_fill_cnt]   = d;
                    m_known[m_fill_bank][m_fill_cnt] = 1;
                    m_fill_cnt++;
                    if (m_fill_cnt == FRAME_LEN) begin
                        m_fill_cnt = 0;
                        m_launch_q.push_back(m_fill_bank);
                        m_occ++;
                        m_fill_bank = 1 - m_fill_bank;
                    end
                end else begin
                    m_overflow = 1;
                    if (m_drops < 255) m_drops++;
                end
            end
            exp_start = 0;
            if (launch) begin
                m_eng_bank = m_launch_q.pop_front();
                m_inflight = 1;
                exp_start  = 1;
            end
            m_start_prev = exp_start;
            m_all_done   = m_all_done | fin_prev;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            eng_timer = 0;
        end else if (auto_eng) begin
            if (eng_timer > 0) eng_timer--;
            if (bus.eng_start === 1'b1) eng_timer = $urandom_range(eng_lat_max, eng_lat_min);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(0, 16'h0, 0, 0, 4'h0);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        auto_eng = 0;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom));
            checks++; if (bus.eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng_start got=%0b exp=0", bus.eng_start); end
            checks++; if (bus.eng_bank !== 1'b0) begin errors++; $display("FAIL reset_eng_bank got=%0b exp=0", bus.eng_bank); end
            checks++; if (bus.eng_rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", bus.eng_rd_data); end
            checks++; if (bus.frame_cnt !== 7'd0) begin errors++; $display("FAIL reset_frame_cnt got=%0d exp=0", bus.frame_cnt); end
            checks++; if (bus.all_done !== 1'b0) begin errors++; $display("FAIL reset_all_done got=%0b exp=0", bus.all_done); end
            checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", bus.overflow); end
`ifdef FFT_CTRL_DROP_CNT_EN
            checks++; if (bus.drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got=%0d exp=0", bus.drop_cnt); end
`endif
        end
        rst = 1'b1;
    endtask

    task automatic test_fill_read();
        auto_eng = 0;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1, 16'(i), 1, 0, 4'h0);
            checks++; if (bus.eng_start !== 1'b0) begin errors++; $display("FAIL fill_early_start i=%0d got=%0b exp=0", i, bus.eng_start); end
        end
        step(0, 16'h0, 1, 0, 4'h0);
        checks++; if (bus.eng_start !== 1'b1) begin errors++; $display("FAIL fill_start got=%0b exp=1", bus.eng_start); end
        checks++; if (bus.eng_bank !== 1'b0) begin errors++; $display("FAIL fill_bank got=%0b exp=0", bus.eng_bank); end
        step(0, 16'h0, 1, 0, 4'h0);
        checks++; if (bus.eng_start !== 1'b0) begin errors++; $display("FAIL fill_start_width got=%0b exp=0", bus.eng_start); end
        for (int a = 0; a < 16; a++) begin
            step(0, 16'h0, 1, 0, 4'(a));
            checks++; if (bus.eng_rd_data !== 16'(a + 1)) begin errors++; $display("FAIL fill_read addr=%0d got=%h exp=%h", a, bus.eng_rd_data, 16'(a + 1)); end
        end
    endtask

    task automatic test_overflow();
        auto_eng = 0;
        do_reset();
        for (int i = 1; i <= 48; i++) begin
            step(1, 16'(i), 1, 0, 4'h0);
            checks++; if (bus.overflow !== m_overflow) begin errors++; $display("FAIL ovf_flag i=%0d got=%0b exp=%0b", i, bus.overflow, m_overflow); end
            checks++; if (bus.eng_start !== exp_start) begin errors++; $display("FAIL ovf_start i=%0d got=%0b exp=%0b", i, bus.eng_start, exp_start); end
        end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_final got=%0b exp=1", bus.overflow); end
`ifdef FFT_CTRL_DROP_CNT_EN
        checks++; if (bus.drop_cnt !== 8'd16) begin errors++; $display("FAIL ovf_drop_cnt got=%0d exp=16", bus.drop_cnt); end
`endif
        step(0, 16'h0, 1, 1, 4'h0);
        checks++; if (bus.frame_cnt !== 7'd1) begin errors++; $display("FAIL ovf_frame_cnt got=%0d exp=1", bus.frame_cnt); end
        step(0, 16'h0, 1, 0, 4'h0);
        checks++; if (bus.eng_start !== 1'b1) begin errors++; $display("FAIL ovf_relaunch got=%0b exp=1", bus.eng_start); end
        checks++; if (bus.eng_bank !== 1'b1) begin errors++; $display("FAIL ovf_relaunch_bank got=%0b exp=1", bus.eng_bank); end
        for (int a = 0; a < 16; a++) begin
            step(0, 16'h0, 1, 0, 4'(a));
            checks++; if (bus.eng_rd_data !== 16'(17 + a)) begin errors++; $display("FAIL ovf_bank1_read addr=%0d got=%h exp=%h", a, bus.eng_rd_data, 16'(17 + a)); end
        end
    endtask

    task automatic test_simultaneous();
        auto_eng = 0;
        do_reset();
        for (int i = 1; i <= 31; i++) step(1, 16'(i), 1, 0, 4'h0);
        step(1, 16'd32, 1, 1, 4'h0);
        checks++; if (bus.frame_cnt !== 7'd1) begin errors++; $display("FAIL sim_frame_cnt got=%0d exp=1", bus.frame_cnt); end
        checks++; if (bus.eng_start !== 1'b0) begin errors++; $display("FAIL sim_no_start got=%0b exp=0", bus.eng_start); end
        step(1, 16'd33, 1, 0, 4'h0);
        checks++; if (bus.eng_start !== 1'b1) begin errors++; $display("FAIL sim_start got=%0b exp=1", bus.eng_start); end
        checks++; if (bus.eng_bank !== 1'b1) begin errors++; $display("FAIL sim_bank got=%0b exp=1", bus.eng_bank); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL sim_overflow got=%0b exp=0", bus.overflow); end
        for (int i = 34; i <= 48; i++) step(1, 16'(i), 1, 1'(i == 40), 4'h0);
        step(0, 16'h0, 1, 0, 4'h0);
        checks++; if (bus.eng_start !== 1'b1) begin errors++; $display("FAIL sim_start2 got=%0b exp=1", bus.eng_start); end
        checks++; if (bus.eng_bank !== 1'b0) begin errors++; $display("FAIL sim_bank2 got=%0b exp=0", bus.eng_bank); end
        step(0, 16'h0, 1, 0, 4'd0);
        checks++; if (bus.eng_rd_data !== 16'd33) begin errors++; $display("FAIL sim_read0 got=%h exp=%h", bus.eng_rd_data, 16'd33); end
        step(0, 16'h0, 1, 0, 4'd15);
        checks++; if (bus.eng_rd_data !== 16'd48) begin errors++; $display("FAIL sim_read15 got=%h exp=%h", bus.eng_rd_data, 16'd48); end
        checks++; if (bus.frame_cnt !== 7'd2) begin errors++; $display("FAIL sim_frame_cnt2 got=%0d exp=2", bus.frame_cnt); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL sim_overflow2 got=%0b exp=0", bus.overflow); end
    endtask

    task automatic test_completion();
        auto_eng = 1; eng_lat_min = 20; eng_lat_max = 20;
        do_reset();
        for (int k = 0; k < 228; k++) begin
            if ((k < 128) && (k % 2 == 0)) step(1, 16'($urandom), 1, 0, 4'($urandom));
            else step(0, 16'h0, 1, 0, 4'($urandom));
            checks++; if (bus.eng_start !== exp_start) begin errors++; $display("FAIL cmp_start cyc=%0d got=%0b exp=%0b", cyc, bus.eng_start, exp_start); end
            checks++; if (bus.eng_bank !== 1'(m_eng_bank)) begin errors++; $display("FAIL cmp_bank cyc=%0d got=%0b exp=%0d", cyc, bus.eng_bank, m_eng_bank); end
            checks++; if (bus.frame_cnt !== 7'(m_frames)) begin errors++; $display("FAIL cmp_frame_cnt cyc=%0d got=%0d exp=%0d", cyc, bus.frame_cnt, m_frames); end
            checks++; if (bus.all_done !== m_all_done) begin errors++; $display("FAIL cmp_all_done cyc=%0d got=%0b exp=%0b", cyc, bus.all_done, m_all_done); end
            if (exp_rd_known) begin
                checks++; if (bus.eng_rd_data !== exp_rd) begin errors++; $display("FAIL cmp_rd_data cyc=%0d got=%h exp=%h", cyc, bus.eng_rd_data, exp_rd); end
            end
        end
        checks++; if (bus.frame_cnt !== 7'd4) begin errors++; $display("FAIL cmp_final_frames got=%0d exp=4", bus.frame_cnt); end
        checks++; if (bus.all_done !== 1'b1) begin errors++; $display("FAIL cmp_final_all_done got=%0b exp=1", bus.all_done); end
        step(1, 16'h1234, 1, 0, 4'h0);
        step(0, 16'h0, 1, 0, 4'h0);
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL cmp_late_overflow got=%0b exp=0", bus.overflow); end
        checks++; if (bus.eng_start !== 1'b0) begin errors++; $display("FAIL cmp_late_start got=%0b exp=0", bus.eng_start); end
        checks++; if (bus.frame_cnt !== 7'd4) begin errors++; $display("FAIL cmp_late_frames got=%0d exp=4", bus.frame_cnt); end
        auto_eng = 0;
    endtask

    task automatic test_mid_reset();
        auto_eng = 0;
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 16'hB000 + 16'(i), 1, 0, 4'h0);
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 16'hA000 + 16'(i), 1, 0, 4'h0);
        step(0, 16'h0, 1, 0, 4'h0);
        checks++; if (bus.eng_start !== 1'b1) begin errors++; $display("FAIL mid_start got=%0b exp=1", bus.eng_start); end
        checks++; if (bus.eng_bank !== 1'b0) begin errors++; $display("FAIL mid_bank got=%0b exp=0", bus.eng_bank); end
        step(0, 16'h0, 1, 0, 4'd0);
        checks++; if (bus.eng_rd_data !== 16'hA000) begin errors++; $display("FAIL mid_read0 got=%h exp=a000", bus.eng_rd_data); end
        step(0, 16'h0, 1, 0, 4'd6);
        checks++; if (bus.eng_rd_data !== 16'hA006) begin errors++; $display("FAIL mid_read6 got=%h exp=a006", bus.eng_rd_data); end
    endtask

    task automatic test_random();
        bit stray;
        auto_eng = 1; eng_lat_min = 2; eng_lat_max = 30;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            for (int k = 0; k < 400; k++) begin
                stray = !m_inflight && ($urandom_range(0, 19) == 0);
                step(1'($urandom_range(0, 9) < 7), 16'($urandom), 1'($urandom_range(0, 9) < 8),
                     stray, 4'($urandom));
                checks++; if (bus.eng_start !== exp_start) begin errors++; $display("FAIL rnd_start cyc=%0d got=%0b exp=%0b", cyc, bus.eng_start, exp_start); end
                checks++; if (bus.eng_bank !== 1'(m_eng_bank)) begin errors++; $display("FAIL rnd_bank cyc=%0d got=%0b exp=%0d", cyc, bus.eng_bank, m_eng_bank); end
                checks++; if (bus.frame_cnt !== 7'(m_frames)) begin errors++; $display("FAIL rnd_frame_cnt cyc=%0d got=%0d exp=%0d", cyc, bus.frame_cnt, m_frames); end
                checks++; if (bus.all_done !== m_all_done) begin errors++; $display("FAIL rnd_all_done cyc=%0d got=%0b exp=%0b", cyc, bus.all_done, m_all_done); end
                checks++; if (bus.overflow !== m_overflow) begin errors++; $display("FAIL rnd_overflow cyc=%0d got=%0b exp=%0b", cyc, bus.overflow, m_overflow); end
`ifdef FFT_CTRL_DROP_CNT_EN
                checks++; if (bus.drop_cnt !== 8'(m_drops)) begin errors++; $display("FAIL rnd_drop_cnt cyc=%0d got=%0d exp=%0d", cyc, bus.drop_cnt, m_drops); end
`endif
                if (exp_rd_known) begin
                    checks++; if (bus.eng_rd_data !== exp_rd) begin errors++; $display("FAIL rnd_rd_data cyc=%0d got=%h exp=%h", cyc, bus.eng_rd_data, exp_rd); end
                end
            end
        end
        auto_eng = 0;
    endtask

    initial begin
        rst = 1'b0;
        auto_eng = 0;
        eng_lat_min = 2;
        eng_lat_max = 2;
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 16; a++) begin
                m_mem[b][a]   = 16'h0;
                m_known[b][a] = 0;
            end
        end
        model_reset();
        test_reset();
        test_fill_read();
        test_overflow();
        test_simultaneous();
        test_completion();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #2000000;
        $display("FAIL watchdog run did not complete errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
